// File: rtl/ssd1331_cmd_sequencer_pkg.sv
// Shared encodings for the SSD1331 command sequencer: opcodes, panel command bytes, FSM states.
package ssd1331_cmd_sequencer_pkg;

   localparam logic [1:0] OP_PIXEL = 2'd0;
   localparam logic [1:0] OP_CLEAR = 2'd1;
   localparam logic [1:0] OP_RECT  = 2'd2;

   localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
   localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
   localparam logic [7:0] CMD_COL_ADDR  = 8'h15;
   localparam logic [7:0] CMD_ROW_ADDR  = 8'h75;
   localparam logic [7:0] CMD_DRAW_RECT = 8'h22;
   localparam logic [7:0] CMD_CLEAR     = 8'h25;
   localparam logic [7:0] CMD_FILL      = 8'h26;

   localparam int         INIT_LEN = 39;
   localparam logic [6:0] X_MAX    = 7'd95;

   typedef enum logic [3:0] {
      ST_PWR_UP, ST_RST_LO, ST_RST_HI, ST_INIT, ST_VCC_WAIT, ST_DISP_ON,
      ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_TX, ST_GAP, ST_ACCEL_WAIT
   } state_t;

   // Which byte source the shared WAIT_TX/GAP path is currently serving.
   typedef enum logic [1:0] {PH_NONE, PH_INIT, PH_DISP, PH_REQ} phase_t;

endpackage

// File: rtl/ssd1331_init_rom.sv
// SSD1331 power-up command table, indexed 0..38; combinational lookup.
module ssd1331_init_rom
   import ssd1331_cmd_sequencer_pkg::*;
(
   input  logic [5:0] idx,
   output logic [7:0] data
);

   always_comb begin
      data = 8'h00;
      case (idx)
         6'd0:  data = CMD_DISP_OFF;
         6'd1:  data = 8'hA0;  6'd2:  data = 8'h72;
         6'd3:  data = 8'hA1;  6'd4:  data = 8'h00;
         6'd5:  data = 8'hA2;  6'd6:  data = 8'h00;
         6'd7:  data = 8'hA4;
         6'd8:  data = 8'hA8;  6'd9:  data = 8'h3F;
         6'd10: data = 8'hAD;  6'd11: data = 8'h8E;
         6'd12: data = 8'hB0;  6'd13: data = 8'h0B;
         6'd14: data = 8'hB1;  6'd15: data = 8'h31;
         6'd16: data = 8'hB3;  6'd17: data = 8'hF0;
         6'd18: data = 8'h8A;  6'd19: data = 8'h64;
         6'd20: data = 8'h8B;  6'd21: data = 8'h78;
         6'd22: data = 8'h8C;  6'd23: data = 8'h64;
         6'd24: data = 8'hBB;  6'd25: data = 8'h3A;
         6'd26: data = 8'hBE;  6'd27: data = 8'h3E;
         6'd28: data = 8'h87;  6'd29: data = 8'h06;
         6'd30: data = 8'h81;  6'd31: data = 8'h91;
         6'd32: data = 8'h82;  6'd33: data = 8'h50;
         6'd34: data = 8'h83;  6'd35: data = 8'h7D;
         6'd36: data = 8'h2E;
         6'd37: data = CMD_FILL; 6'd38: data = 8'h01;
         default: data = 8'h00;
      endcase
   end

endmodule

// File: rtl/ssd1331_cmd_sequencer.sv
// SSD1331 power-up sequencer and draw-request byte issuer for an 8-bit SPI shifter.
// Define SSD1331_RECT_EN to build the hardware-accelerated rectangle operation.
//
// state       | meaning
// PWR_UP      | PMODEN on, settle RST_CYCLES
// RST_LO      | RES_N low for RST_CYCLES
// RST_HI      | RES_N high, wait RST_CYCLES
// INIT        | start one init ROM byte
// VCC_WAIT    | VCCEN on, wait VCC_DELAY_CYCLES
// DISP_ON     | start display-on byte
// IDLE        | ready for a request
// LOAD        | validate latched request, build byte list
// SEND        | start one request byte
// WAIT_TX     | wait for shifter FINAL_TX
// GAP         | one idle cycle, pick next byte source
// ACCEL_WAIT  | let the panel finish a clear/rect
module ssd1331_cmd_sequencer
   import ssd1331_cmd_sequencer_pkg::*;
#(
   parameter int RST_CYCLES        = 30,
   parameter int VCC_DELAY_CYCLES  = 1000000,
   parameter int ACCEL_WAIT_CYCLES = 4000
) (
   input  logic        i_SCK,
   input  logic        i_RST_N,
   input  logic        i_REQ_VALID,
   output logic        o_REQ_READY,
   input  logic [1:0]  i_REQ_OP,
   input  logic [6:0]  i_REQ_X0,
   input  logic [6:0]  i_REQ_X1,
   input  logic [5:0]  i_REQ_Y0,
   input  logic [5:0]  i_REQ_Y1,
   input  logic [15:0] i_REQ_COLOR,
   output logic        o_REQ_ERR,
   output logic        o_INIT_DONE,
   output logic [7:0]  o_SPI_DATA,
   output logic        o_SPI_DC,
   output logic        o_SPI_START,
   input  logic        i_SPI_FINAL_TX,
   output logic        o_OLED_RES_N,
   output logic        o_OLED_VCCEN,
   output logic        o_OLED_PMODEN
);

   localparam int MAX_A   = (RST_CYCLES > VCC_DELAY_CYCLES) ? RST_CYCLES : VCC_DELAY_CYCLES;
   localparam int MAX_DLY = (MAX_A > ACCEL_WAIT_CYCLES) ? MAX_A : ACCEL_WAIT_CYCLES;
   localparam int WAIT_W  = (MAX_DLY > 2) ? $clog2(MAX_DLY) : 1;
   localparam logic [WAIT_W-1:0] RST_LD   = WAIT_W'(RST_CYCLES - 1);
   localparam logic [WAIT_W-1:0] VCC_LD   = WAIT_W'(VCC_DELAY_CYCLES - 1);
   localparam logic [WAIT_W-1:0] ACCEL_LD = WAIT_W'(ACCEL_WAIT_CYCLES - 1);

   state_t            state, nxt_state;
   phase_t            phase, nxt_phase;
   logic [WAIT_W-1:0] wait_cnt, nxt_wait;
   logic [5:0]        rom_idx, nxt_rom_idx;
   logic [3:0]        idx, nxt_idx, last;
   logic              accel, vccen, nxt_vccen, pmoden, init_done, nxt_init_done;
   logic [7:0]        rom_byte;

   logic [1:0]  req_op;
   logic [6:0]  req_x0, req_x1;
   logic [5:0]  req_y0, req_y1;
   logic [15:0] req_color;

   logic [8:0]  blist [13];
   logic [8:0]  blist_new [13];
   logic [3:0]  blast;
   logic        baccel, bad;

   ssd1331_init_rom u_rom (.idx(rom_idx), .data(rom_byte));

   // Byte list for the latched request; entries are {DC, byte}.
   always_comb begin
      for (int i = 0; i < 13; i++) blist_new[i] = 9'h000;
      blast  = 4'd0;
      baccel = 1'b0;
      bad    = 1'b0;
      case (req_op)
         OP_PIXEL: begin
            bad          = req_x0 > X_MAX;
            blast        = 4'd7;
            blist_new[0] = {1'b0, CMD_COL_ADDR};
            blist_new[1] = {2'b00, req_x0};
            blist_new[2] = {2'b00, req_x0};
            blist_new[3] = {1'b0, CMD_ROW_ADDR};
            blist_new[4] = {3'b000, req_y0};
            blist_new[5] = {3'b000, req_y0};
            blist_new[6] = {1'b1, req_color[15:8]};
            blist_new[7] = {1'b1, req_color[7:0]};
         end
         OP_CLEAR: begin
            blast        = 4'd4;
            baccel       = 1'b1;
            blist_new[0] = {1'b0, CMD_CLEAR};
            blist_new[3] = 9'h05F;
            blist_new[4] = 9'h03F;
         end
`ifdef SSD1331_RECT_EN
         OP_RECT: begin
            bad          = (req_x0 > X_MAX) || (req_x1 > X_MAX) ||
                           (req_x0 > req_x1) || (req_y0 > req_y1);
            blast        = 4'd10;
            baccel       = 1'b1;
            blist_new[0] = {1'b0, CMD_DRAW_RECT};
            blist_new[1] = {2'b00, req_x0};
            blist_new[2] = {3'b000, req_y0};
            blist_new[3] = {2'b00, req_x1};
            blist_new[4] = {3'b000, req_y1};
            for (int k = 0; k < 2; k++) begin
               blist_new[5+3*k] = {3'b000, req_color[15:11], 1'b0};
               blist_new[6+3*k] = {3'b000, req_color[10:5]};
               blist_new[7+3*k] = {3'b000, req_color[4:0], 1'b0};
            end
         end
`endif
         default: bad = 1'b1;
      endcase
   end

`ifndef SSD1331_RECT_EN
   logic rect_unused;
   assign rect_unused = ^{req_x1, req_y1};
`endif

   always_comb begin
      nxt_state     = state;
      nxt_phase     = phase;
      nxt_wait      = wait_cnt;
      nxt_rom_idx   = rom_idx;
      nxt_idx       = idx;
      nxt_vccen     = vccen;
      nxt_init_done = init_done;
      case (state)
         ST_PWR_UP, ST_RST_LO: begin
            if (wait_cnt == '0) begin
               nxt_state = (state == ST_PWR_UP) ? ST_RST_LO : ST_RST_HI;
               nxt_wait  = RST_LD;
            end else nxt_wait = wait_cnt - WAIT_W'(1);
         end
         ST_RST_HI: begin
            if (wait_cnt == '0) begin
               nxt_state   = ST_INIT;
               nxt_phase   = PH_INIT;
               nxt_rom_idx = 6'd0;
            end else nxt_wait = wait_cnt - WAIT_W'(1);
         end
         ST_INIT, ST_DISP_ON, ST_SEND: nxt_state = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (i_SPI_FINAL_TX) begin
               nxt_state = ST_GAP;
               if (phase == PH_DISP) nxt_init_done = 1'b1;
            end
         end
         ST_GAP: begin
            case (phase)
               PH_INIT: begin
                  if (rom_idx == 6'(INIT_LEN - 1)) begin
                     nxt_state = ST_VCC_WAIT;
                     nxt_wait  = VCC_LD;
                     nxt_vccen = 1'b1;
                  end else begin
                     nxt_state   = ST_INIT;
                     nxt_rom_idx = rom_idx + 6'd1;
                  end
               end
               PH_DISP: nxt_state = ST_IDLE;
               default: begin
                  if (idx == last) begin
                     nxt_state = accel ? ST_ACCEL_WAIT : ST_IDLE;
                     nxt_wait  = ACCEL_LD;
                  end else begin
                     nxt_state = ST_SEND;
                     nxt_idx   = idx + 4'd1;
                  end
               end
            endcase
         end
         ST_VCC_WAIT: begin
            if (wait_cnt == '0) begin
               nxt_state = ST_DISP_ON;
               nxt_phase = PH_DISP;
            end else nxt_wait = wait_cnt - WAIT_W'(1);
         end
         ST_IDLE: if (i_REQ_VALID) nxt_state = ST_LOAD;
         ST_LOAD: begin
            if (bad) nxt_state = ST_IDLE;
            else begin
               nxt_state = ST_SEND;
               nxt_phase = PH_REQ;
               nxt_idx   = 4'd0;
            end
         end
         ST_ACCEL_WAIT: begin
            if (wait_cnt == '0) nxt_state = ST_IDLE;
            else nxt_wait = wait_cnt - WAIT_W'(1);
         end
         default: nxt_state = ST_PWR_UP;
      endcase
   end

   always_ff @(posedge i_SCK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state     <= ST_PWR_UP;
         phase     <= PH_NONE;
         wait_cnt  <= RST_LD;
         rom_idx   <= 6'd0;
         idx       <= 4'd0;
         vccen     <= 1'b0;
         pmoden    <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= nxt_state;
         phase     <= nxt_phase;
         wait_cnt  <= nxt_wait;
         rom_idx   <= nxt_rom_idx;
         idx       <= nxt_idx;
         vccen     <= nxt_vccen;
         pmoden    <= 1'b1;
         init_done <= nxt_init_done;
      end
   end

   always_ff @(posedge i_SCK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         req_op    <= 2'd0;
         req_x0    <= 7'd0;
         req_x1    <= 7'd0;
         req_y0    <= 6'd0;
         req_y1    <= 6'd0;
         req_color <= 16'h0000;
         last      <= 4'd0;
         accel     <= 1'b0;
         for (int i = 0; i < 13; i++) blist[i] <= 9'h000;
      end else begin
         if (state == ST_IDLE && i_REQ_VALID) begin
            req_op    <= i_REQ_OP;
            req_x0    <= i_REQ_X0;
            req_x1    <= i_REQ_X1;
            req_y0    <= i_REQ_Y0;
            req_y1    <= i_REQ_Y1;
            req_color <= i_REQ_COLOR;
         end
         if (state == ST_LOAD && !bad) begin
            last  <= blast;
            accel <= baccel;
            for (int i = 0; i < 13; i++) blist[i] <= blist_new[i];
         end
      end
   end

   always_comb begin
      o_SPI_DATA = 8'h00;
      o_SPI_DC   = 1'b0;
      case (phase)
         PH_INIT: o_SPI_DATA = rom_byte;
         PH_DISP: o_SPI_DATA = CMD_DISP_ON;
         PH_REQ:  {o_SPI_DC, o_SPI_DATA} = blist[idx];
         default: o_SPI_DATA = 8'h00;
      endcase
   end

   assign o_REQ_READY   = (state == ST_IDLE);
   assign o_REQ_ERR     = (state == ST_LOAD) && bad;
   assign o_SPI_START   = (state == ST_INIT) || (state == ST_DISP_ON) || (state == ST_SEND);
   assign o_INIT_DONE   = init_done;
   assign o_OLED_RES_N  = (state != ST_RST_LO);
   assign o_OLED_VCCEN  = vccen;
   assign o_OLED_PMODEN = pmoden;

endmodule
